div: RTL
========

# div

Multi-cycle radix-2 divider serving the execute stage for `div`/`divu`. The execute stage starts a divide and holds its stall request until `ready_o` rises. It then writes `result_o[63:32]` to Hi and `result_o[31:0]` to Lo. The block owns the divide handshake; the execute stage only raises `start_i`, and the block answers with `ready_o`.

## Interface
- Parameters: none; the operand width is fixed at 32 (`RegBus`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `signed_div_i`  in  1  1 = signed (`div`), 0 = unsigned (`divu`); sampled with `start_i`.
- `opdata1_i`  in  32  dividend; sampled with `start_i`.
- `opdata2_i`  in  32  divisor; sampled with `start_i`.
- `start_i`  in  1  divide request; held high by the execute stage until it observes `ready_o`.
- `annul_i`  in  1  cancel request (pipeline flush); has priority over `start_i`.
- `result_o`  out  64  `{remainder, quotient}`; registered.
- `ready_o`  out  1  result valid; registered.

## Operation
- States: IDLE, DIVZERO, BUSY, DONE. Iteration counter `cnt` is 6 bits.
- Reset (`rst`=0, asynchronous):
  - state goes to IDLE and `cnt` clears to 0;
  - `result_o` = 0 and `ready_o` = 0;
  - any operation in progress is aborted.
- IDLE:
  - On an edge with `start_i`=1 and `annul_i`=0, latch the operands and sign mode.
  - Divisor = 0: go to DIVZERO.
  - Divisor ≠ 0: go to BUSY with `cnt`=0.
  - Otherwise stay in IDLE.
- Operand preparation at latch:
  - If `signed_div_i`=1, each negative operand is replaced by its two's-complement magnitude.
  - Record `q_neg` = sign(op1) XOR sign(op2) and `r_neg` = sign(op1).
  - Both flags are 0 for unsigned divides.
- BUSY: one restoring step per edge.
  - Form a 33-bit trial = partial remainder − divisor.
  - Trial non-negative: the partial remainder takes the trial value and the next quotient bit is 1.
  - Trial negative: the next quotient bit is 0.
  - Shift left by one and increment `cnt`.
- BUSY completion, on the edge where `cnt`=32:
  - quotient is negated if `q_neg`; remainder is negated if `r_neg`;
  - `result_o` ← `{rem, quo}`, `ready_o` ← 1, go to DONE.
- DIVZERO: on the next edge `result_o` ← 0, `ready_o` ← 1, go to DONE. The architectural result is unpredictable, and the block defines it as 0.
- DONE:
  - `result_o` and `ready_o`=1 hold while `start_i`=1.
  - On an edge with `start_i`=0 or `annul_i`=1, go to IDLE with `ready_o` ← 0 and `result_o` ← 0.
- `annul_i`=1 in BUSY or DIVZERO: on that edge go to IDLE with `ready_o`=0, `result_o`=0, `cnt`=0. No result is produced.
- No overflow trap. Signed 0x80000000 / −1 gives quotient 0x80000000, remainder 0.
- Operand inputs are ignored outside the IDLE accept edge. Changes to them during BUSY have no effect.

## Timing
- Start accept edge = E0.
- Nonzero divisor: iterations occur on E1..E32; the result is registered and `ready_o`=1 from E33. `ready_o` is visible 33 cycles after accept.
- Zero divisor: `ready_o`=1 from E1.
- `ready_o` stays high at least one cycle, and stays high for as long as `start_i` remains 1.
- After DONE → IDLE, the earliest new accept is the following edge. `start_i` must have been sampled 0 on the DONE exit edge, so a held `start_i` never double-issues.
- `annul_i` and `start_i` asserted together in IDLE: the request is ignored.

## Test plan
- Unsigned: 100 / 7, `signed_div_i`=0 → after 33 cycles `ready_o`=1, `result_o` = {0x00000002, 0x0000000E}. Also 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Signed:
  - −7 / 2 → {0xFFFFFFFF, 0xFFFFFFFD};
  - 7 / −2 → {0x00000001, 0xFFFFFFFD};
  - −7 / −2 → {0xFFFFFFFF, 0x00000003};
  - 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}.
- Divide by zero: opdata1=1234, opdata2=0, start → `ready_o`=1 after 1 cycle, `result_o`=0. Deassert `start_i` → next cycle `ready_o`=0.
- Annul: start 100/7, assert `annul_i` at E10 → IDLE next cycle, `ready_o` never rises. A following start of 9/3 yields {0, 3} 33 cycles after its accept.
- DONE hold: keep `start_i`=1 for 5 cycles after `ready_o` → result stable and no new divide begins. Drop `start_i` → `ready_o`=0 and `result_o`=0.
- Async reset: pull `rst` low mid-BUSY (E15), between clock edges → outputs 0 immediately. Release, then start 50/5 → {0, 10} after 33 cycles.

Source files
------------

// File: rtl/div.sv
// Multi-cycle restoring radix-2 divider for div/divu.
// Result is {remainder, quotient}; ready_o holds while start_i stays high.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {StIdle, StDivZero, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic        op1_neg, op2_neg;
  logic [31:0] op1_mag, op2_mag;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] quo_fin, rem_fin;

  always_comb begin
    op1_neg = signed_div_i & opdata1_i[31];
    op2_neg = signed_div_i & opdata2_i[31];
    op1_mag = op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
    op2_mag = op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;
    // Partial remainder stays below the divisor, so bit 32 of the trial is its sign.
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dvs_q};
    quo_fin = q_neg_q ? (~quo_q + 32'd1) : quo_q;
    rem_fin = r_neg_q ? (~rem_q + 32'd1) : rem_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      StIdle: begin
        if (start_i && !annul_i) begin
          dvs_d   = op2_mag;
          quo_d   = op1_mag;
          rem_d   = 32'd0;
          q_neg_d = op1_neg ^ op2_neg;
          r_neg_d = op1_neg;
          cnt_d   = 6'd0;
          state_d = (opdata2_i == 32'd0) ? StDivZero : StBusy;
        end
      end
      StDivZero: begin
        if (annul_i) begin
          state_d  = StIdle;
          cnt_d    = 6'd0;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end else begin
          state_d  = StDone;
          result_d = 64'd0;
          ready_d  = 1'b1;
        end
      end
      StBusy: begin
        if (annul_i) begin
          state_d  = StIdle;
          cnt_d    = 6'd0;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end else if (cnt_q == 6'd32) begin
          state_d  = StDone;
          result_d = {rem_fin, quo_fin};
          ready_d  = 1'b1;
        end else begin
          rem_d = trial[32] ? shifted[31:0] : trial[31:0];
          quo_d = {quo_q[30:0], ~trial[32]};
          cnt_d = cnt_q + 6'd1;
        end
      end
      StDone: begin
        if (!start_i || annul_i) begin
          state_d  = StIdle;
          cnt_d    = 6'd0;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= 6'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
